// File: rtl/ripple_carry_adder_pkg.sv
// Shared arithmetic constants for the ripple-carry adder and the wrappers
// that cascade it into wider sums.
package ripple_carry_adder_pkg;

    // Nibble size shared by every cascaded instance.
    localparam int RCA_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// Single-bit full adder: one stage of the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Parameterised ripple-carry adder with carry in/out, signed overflow flag
// and an optional output register stage.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH   = RCA_DEFAULT_WIDTH,
    parameter bit OUT_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic             v_c;

    assign c[0] = Cin;

    // Carry ripples strictly stage to stage.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (sum_c[i]),
            .co (c[i+1])
        );
    end

    assign cout_c = c[WIDTH];
    assign v_c    = c[WIDTH] ^ c[WIDTH-1];

    if (OUT_REG) begin : g_out_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                S    <= '0;
                Cout <= 1'b0;
                V    <= 1'b0;
            end else begin
                S    <= sum_c;
                Cout <= cout_c;
                V    <= v_c;
            end
        end
    end else begin : g_out_comb
        // Clock and reset are deliberately inert in combinational mode.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign S    = sum_c;
        assign Cout = cout_c;
        assign V    = v_c;
    end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed and sweep checks of ripple_carry_adder in combinational,
// cascaded and registered configurations.
module tb_ripple_carry_adder;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 combinational
    logic [3:0] a4, b4, s4;
    logic       ci4, co4, v4;
    ripple_carry_adder #(.WIDTH(4), .OUT_REG(1'b0)) u_c4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(ci4),
        .S(s4), .Cout(co4), .V(v4));

    // Three nibbles cascaded into 12 bits
    logic [11:0] ca, cb, cs;
    logic [2:0]  cco, cv;
    ripple_carry_adder #(.WIDTH(4), .OUT_REG(1'b0)) u_n0 (
        .clk(clk), .rst_n(rst_n), .A(ca[3:0]), .B(cb[3:0]), .Cin(1'b0),
        .S(cs[3:0]), .Cout(cco[0]), .V(cv[0]));
    ripple_carry_adder #(.WIDTH(4), .OUT_REG(1'b0)) u_n1 (
        .clk(clk), .rst_n(rst_n), .A(ca[7:4]), .B(cb[7:4]), .Cin(cco[0]),
        .S(cs[7:4]), .Cout(cco[1]), .V(cv[1]));
    ripple_carry_adder #(.WIDTH(4), .OUT_REG(1'b0)) u_n2 (
        .clk(clk), .rst_n(rst_n), .A(ca[11:8]), .B(cb[11:8]), .Cin(cco[1]),
        .S(cs[11:8]), .Cout(cco[2]), .V(cv[2]));

    // WIDTH=4 registered
    logic [3:0] ra, rb, rs;
    logic       rci, rco, rv;
    ripple_carry_adder #(.WIDTH(4), .OUT_REG(1'b1)) u_r4 (
        .clk(clk), .rst_n(rst_n), .A(ra), .B(rb), .Cin(rci),
        .S(rs), .Cout(rco), .V(rv));

    // WIDTH=1 and WIDTH=16 combinational
    logic       a1, b1, ci1, s1, co1, v1;
    ripple_carry_adder #(.WIDTH(1), .OUT_REG(1'b0)) u_c1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(ci1),
        .S(s1), .Cout(co1), .V(v1));

    logic [15:0] a16, b16, s16;
    logic        ci16, co16, v16;
    ripple_carry_adder #(.WIDTH(16), .OUT_REG(1'b0)) u_c16 (
        .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(ci16),
        .S(s16), .Cout(co16), .V(v16));

    int n_vec;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Signed overflow reference for a 4-bit add with carry-in.
    function automatic logic ovf4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        int sa, sb, r;
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        r  = sa + sb + int'(ci);
        return (r > 7) || (r < -8);
    endfunction

    initial begin
        logic [4:0]  exp5;
        logic [16:0] exp17;
        logic [1:0]  exp2;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        a4 = '0; b4 = '0; ci4 = 1'b0;
        ca = '0; cb = '0;
        ra = '0; rb = '0; rci = 1'b0;
        a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
        a16 = '0; b16 = '0; ci16 = 1'b0;

        // Combinational directed vectors
        a4 = 4'h5; b4 = 4'h3; ci4 = 1'b0; #1;
        check("c4 5+3 S", 32'(s4), 32'h8);
        check("c4 5+3 Cout", 32'(co4), 32'h0);
        check("c4 5+3 V", 32'(v4), 32'h1);
        a4 = 4'hF; b4 = 4'h1; ci4 = 1'b0; #1;
        check("c4 F+1 S", 32'(s4), 32'h0);
        check("c4 F+1 Cout", 32'(co4), 32'h1);
        check("c4 F+1 V", 32'(v4), 32'h0);
        a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1; #1;
        check("c4 F+F+1 S", 32'(s4), 32'hF);
        check("c4 F+F+1 Cout", 32'(co4), 32'h1);
        check("c4 F+F+1 V", 32'(v4), 32'h0);

        // Exhaustive WIDTH=4 sweep
        for (int i = 0; i < 512; i++) begin
            a4 = i[3:0]; b4 = i[7:4]; ci4 = i[8]; #1;
            exp5 = {1'b0, a4} + {1'b0, b4} + {4'b0, ci4};
            check("c4 sweep sum", 32'({co4, s4}), 32'(exp5));
            check("c4 sweep V", 32'(v4), 32'(ovf4(a4, b4, ci4)));
        end

        // Cascaded 12-bit
        ca = 12'h0E9; cb = 12'h179; #1;
        check("casc 0E9+179 S", 32'(cs), 32'h262);
        check("casc 0E9+179 Cout", 32'(cco[2]), 32'h0);
        ca = 12'hFFF; cb = 12'h001; #1;
        check("casc FFF+001 S", 32'(cs), 32'h000);
        check("casc FFF+001 Cout", 32'(cco[2]), 32'h1);

        // WIDTH=16 directed then random
        a16 = 16'hFFFF; b16 = 16'h0001; ci16 = 1'b0; #1;
        check("c16 FFFF+1 S", 32'(s16), 32'h0000);
        check("c16 FFFF+1 Cout", 32'(co16), 32'h1);
        for (int i = 0; i < 64; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom); #1;
            exp17 = {1'b0, a16} + {1'b0, b16} + {16'b0, ci16};
            check("c16 random", 32'({co16, s16}), 32'(exp17));
        end

        // WIDTH=1 all combinations plus random
        for (int i = 0; i < 8; i++) begin
            a1 = i[0]; b1 = i[1]; ci1 = i[2]; #1;
            exp2 = {1'b0, a1} + {1'b0, b1} + {1'b0, ci1};
            check("c1 sum", 32'({co1, s1}), 32'(exp2));
            check("c1 V", 32'(v1), 32'(co1 ^ (a1 ^ b1 ? ~ci1 & 1'b0 : 1'b0) ^ (((a1 & b1) | (ci1 & (a1 ^ b1))) ^ ci1) ^ co1));
        end
        for (int i = 0; i < 16; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom); #1;
            exp2 = {1'b0, a1} + {1'b0, b1} + {1'b0, ci1};
            check("c1 random", 32'({co1, s1}), 32'(exp2));
        end

        // Registered mode: reset, latency, async reset
        ra = 4'h9; rb = 4'h9; rci = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("r4 in reset S", 32'(rs), 32'h0);
        check("r4 in reset Cout", 32'(rco), 32'h0);
        check("r4 in reset V", 32'(rv), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ra = 4'h7; rb = 4'h2; rci = 1'b1; #1;
        check("r4 before edge S", 32'(rs), 32'h0);
        @(posedge clk); #1;
        check("r4 7+2+1 S", 32'(rs), 32'hA);
        check("r4 7+2+1 Cout", 32'(rco), 32'h0);
        check("r4 7+2+1 V", 32'(rv), 32'h1);
        @(negedge clk);
        ra = 4'hF; rb = 4'h1; rci = 1'b0; #1;
        check("r4 hold S", 32'(rs), 32'hA);
        @(posedge clk); #1;
        check("r4 F+1 S", 32'(rs), 32'h0);
        check("r4 F+1 Cout", 32'(rco), 32'h1);
        check("r4 F+1 V", 32'(rv), 32'h0);
        @(negedge clk);
        ra = 4'h7; rb = 4'h2; rci = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("r4 async rst S", 32'(rs), 32'h0);
        check("r4 async rst Cout", 32'(rco), 32'h0);
        check("r4 async rst V", 32'(rv), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("r4 after rst S", 32'(rs), 32'hA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
